// File: rtl/alu_sequencer_if.sv
`timescale 1ns/1ps
// alu_sequencer_if
//   Groups the instruction handshake and the bus-control strobes of the
//   shared-bus ALU sequencer. The shared data bus itself stays a plain inout
//   port on the sequencer, because it is a resolved net with several drivers.
//
//   Instruction side (issuer -> sequencer):
//     instValid, instOp[3:0], instRd, instRs1, instRs2, instImm
//   Instruction side (sequencer -> issuer):
//     instReady, done, instErr
//   Bus control (sequencer -> register file / ALU):
//     regOutEn, regOutSel, regInEn, regInSel,
//     aluEnIn1, aluEnIn2, aluOpCode[3:0], aluOutEn
//
//   Modport slave is the sequencer. Modport master is the instruction issuer,
//   which also observes the bus strobes.
interface alu_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  instValid;
  logic                  instReady;
  logic [3:0]            instOp;
  logic [REG_ADDR_W-1:0] instRd;
  logic [REG_ADDR_W-1:0] instRs1;
  logic [REG_ADDR_W-1:0] instRs2;
  logic [DATA_W-1:0]     instImm;
  logic                  done;
  logic                  instErr;

  logic                  regOutEn;
  logic [REG_ADDR_W-1:0] regOutSel;
  logic                  regInEn;
  logic [REG_ADDR_W-1:0] regInSel;
  logic                  aluEnIn1;
  logic                  aluEnIn2;
  logic [3:0]            aluOpCode;
  logic                  aluOutEn;

  modport slave (
    input  instValid, instOp, instRd, instRs1, instRs2, instImm,
    output instReady, done, instErr,
    output regOutEn, regOutSel, regInEn, regInSel,
    output aluEnIn1, aluEnIn2, aluOpCode, aluOutEn
  );

  modport master (
    output instValid, instOp, instRd, instRs1, instRs2, instImm,
    input  instReady, done, instErr,
    input  regOutEn, regOutSel, regInEn, regInSel,
    input  aluEnIn1, aluEnIn2, aluOpCode, aluOutEn
  );
endinterface

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// alu_sequencer
//   Bus-side initiator for the shared-bus ALU. Takes one instruction per
//   handshake and walks the 16-bit shared bus through three transfers:
//   rs1 -> ALU in1, rs2 or immediate -> ALU in2, ALU result -> rd.
//   Every transfer is two cycles: a SET cycle that turns the source on, and a
//   LAT cycle that keeps the source and raises the load strobe, so loads only
//   ever see a settled bus. Because this block owns every bus enable, at most
//   one driver is on the bus in any cycle.
//
//   Ports:
//     clk   single clock, all state changes on posedge
//     rstN  asynchronous active-low reset, aborts any operation in flight
//     ctl   alu_sequencer_if.slave: instruction handshake + bus strobes
//     bus   shared data bus; driven here only with the immediate, else Z
module alu_sequencer #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rstN,
  alu_sequencer_if.slave    ctl,
  inout  wire  [DATA_W-1:0] bus
);

  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SUBI = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd8;

  typedef enum logic [2:0] {
    IDLE, S1_SET, S1_LAT, S2_SET, S2_LAT, EXEC, WB_SET, WB_LAT
  } state_t;

  state_t                state, next_state;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q, rs2_q;
  logic [DATA_W-1:0]     imm_q;
  logic                  drive_imm;

  logic                  accept, op_ok, imm_op;
  logic                  reg_out_en_n, reg_in_en_n, alu_en1_n, alu_en2_n;
  logic                  alu_out_en_n, drive_imm_n, done_n, inst_err_n;
  logic [REG_ADDR_W-1:0] reg_out_sel_n, reg_in_sel_n;

  assign accept = ctl.instValid && ctl.instReady;
  assign op_ok  = (ctl.instOp <= OP_MAX);
  assign imm_op = (op_q == OP_ADDI) || (op_q == OP_SUBI);

  // The immediate is the only value this block ever puts on the bus.
  assign bus = drive_imm ? imm_q : 'z;

  // Next state, then the output values that belong to that next state, so
  // every output can be registered and still line up with its state.
  // Selects hold their last value when not in use.
  always_comb begin
    next_state    = state;
    reg_out_en_n  = 1'b0;
    reg_out_sel_n = ctl.regOutSel;
    reg_in_en_n   = 1'b0;
    reg_in_sel_n  = ctl.regInSel;
    alu_en1_n     = 1'b0;
    alu_en2_n     = 1'b0;
    alu_out_en_n  = 1'b0;
    drive_imm_n   = 1'b0;
    done_n        = 1'b0;
    inst_err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (op_ok) next_state = S1_SET;
          else       inst_err_n = 1'b1;
        end
      end
      S1_SET:  next_state = S1_LAT;
      S1_LAT:  next_state = (op_q == OP_NOT) ? EXEC : S2_SET;
      S2_SET:  next_state = S2_LAT;
      S2_LAT:  next_state = EXEC;
      EXEC:    next_state = WB_SET;
      WB_SET:  next_state = WB_LAT;
      WB_LAT: begin
        next_state = IDLE;
        done_n     = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    case (next_state)
      // S1_SET is only ever entered straight from IDLE, so rs1 comes from
      // the instruction port rather than the captured copy.
      S1_SET: begin
        reg_out_en_n  = 1'b1;
        reg_out_sel_n = ctl.instRs1;
      end
      S1_LAT: begin
        reg_out_en_n = 1'b1;
        alu_en1_n    = 1'b1;
      end
      S2_SET, S2_LAT: begin
        if (imm_op) begin
          drive_imm_n = 1'b1;
        end else begin
          reg_out_en_n  = 1'b1;
          reg_out_sel_n = rs2_q;
        end
        alu_en2_n = (next_state == S2_LAT);
      end
      WB_SET: begin
        alu_out_en_n = 1'b1;
        reg_in_sel_n = rd_q;
      end
      WB_LAT: begin
        alu_out_en_n = 1'b1;
        reg_in_en_n  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, instruction capture and all registered outputs. A rejected
  // opcode is never captured, so aluOpCode keeps the last good opcode.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      drive_imm     <= 1'b0;
      ctl.instReady <= 1'b1;
      ctl.done      <= 1'b0;
      ctl.instErr   <= 1'b0;
      ctl.regOutEn  <= 1'b0;
      ctl.regOutSel <= '0;
      ctl.regInEn   <= 1'b0;
      ctl.regInSel  <= '0;
      ctl.aluEnIn1  <= 1'b0;
      ctl.aluEnIn2  <= 1'b0;
      ctl.aluOpCode <= '0;
      ctl.aluOutEn  <= 1'b0;
    end else begin
      state         <= next_state;
      drive_imm     <= drive_imm_n;
      ctl.instReady <= (next_state == IDLE);
      ctl.done      <= done_n;
      ctl.instErr   <= inst_err_n;
      ctl.regOutEn  <= reg_out_en_n;
      ctl.regOutSel <= reg_out_sel_n;
      ctl.regInEn   <= reg_in_en_n;
      ctl.regInSel  <= reg_in_sel_n;
      ctl.aluEnIn1  <= alu_en1_n;
      ctl.aluEnIn2  <= alu_en2_n;
      ctl.aluOutEn  <= alu_out_en_n;
      if (accept && op_ok) begin
        op_q          <= ctl.instOp;
        rd_q          <= ctl.instRd;
        rs2_q         <= ctl.instRs2;
        imm_q         <= ctl.instImm;
        ctl.aluOpCode <= ctl.instOp;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
// tb_alu_sequencer
//   Drives instruction streams into alu_sequencer, with a behavioural
//   register file and ALU hanging on the shared bus. Expected behaviour comes
//   from a per-instruction timeline (latency rules) and a shadow register
//   file updated with plain arithmetic.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int RW = 3;

  typedef struct {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [DW-1:0] imm;
  } inst_t;

  logic          clk = 1'b0;
  logic          rstN;
  wire  [DW-1:0] bus;

  alu_sequencer_if #(.DATA_W(DW), .REG_ADDR_W(RW)) ifc();

  alu_sequencer #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .ctl  (ifc),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf     [8];
  logic [DW-1:0] shadow [8];
  logic          load_en   = 1'b0;
  logic [RW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] alu_a = '0, alu_b = '0, alu_res;
  int            checks   = 0;
  int            failures = 0;
  inst_t         prog[$];

  // Register file on the bus: drives the selected register, loads on write
  always @(posedge clk) begin
    if (ifc.regInEn)  rf[ifc.regInSel] <= bus;
    else if (load_en) rf[load_addr]    <= load_data;
  end

  // ALU on the bus: operand latches plus combinational result
  always @(posedge clk) begin
    if (ifc.aluEnIn1) alu_a <= bus;
    if (ifc.aluEnIn2) alu_b <= bus;
  end

  always_comb begin
    alu_res = '0;
    case (ifc.aluOpCode)
      4'd0, 4'd7: alu_res = alu_a + alu_b;
      4'd1, 4'd8: alu_res = alu_a + ~alu_b + 16'd1;
      4'd2:       alu_res = ~alu_a;
      4'd3:       alu_res = alu_a & alu_b;
      4'd4:       alu_res = alu_a | alu_b;
      4'd5:       alu_res = alu_a ^ alu_b;
      4'd6:       alu_res = ~(alu_a ^ alu_b);
      default:    alu_res = '0;
    endcase
  end

  assign bus = ifc.regOutEn ? rf[ifc.regOutSel] : 'z;
  assign bus = ifc.aluOutEn ? alu_res : 'z;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctlVector();
    return {ifc.instReady, ifc.regOutEn, ifc.aluEnIn1, ifc.aluEnIn2,
            ifc.aluOutEn, ifc.regInEn, ifc.done, ifc.instErr};
  endfunction

  function automatic logic [DW-1:0] refResult(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] imm);
    int unsigned ua = a, ub = b, ui = imm;
    case (op)
      4'd0: return DW'((ua + ub) % 65536);
      4'd1: return DW'((ua + 65536 - ub) % 65536);
      4'd2: return DW'(65535 - ua);
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return DW'(65535 - (a ^ b));
      4'd7: return DW'((ua + ui) % 65536);
      4'd8: return DW'((ua + 65536 - ui) % 65536);
      default: return '0;
    endcase
  endfunction

  task automatic setReg(input logic [RW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1 load_en = 1'b0;
    shadow[addr] = data;
  endtask

  function automatic inst_t mk(input logic [3:0] op, input logic [RW-1:0] rd,
                               input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                               input logic [DW-1:0] imm);
    inst_t i;
    i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    return i;
  endfunction

  // Runs everything queued in prog with instValid held high, predicting the
  // accept edges from the latency rules, checking each cycle's strobes and
  // the register file at the end.
  task automatic applyStimulus();
    int    nxt = 0, t = 0, ta = 0, rel = 0, lat = 0;
    bit    active = 0, pend = 0, err = 0, isnot = 0, isimm = 0, ready = 0;
    bit    run = 1, finished_ok = 0;
    inst_t c;
    logic [DW-1:0] res = '0;
    logic [7:0]    ev;
    c = mk(0, 0, 0, 0, 0);
    @(negedge clk);
    while (run) begin
      if (pend) begin
        c      = prog[nxt];
        nxt++;
        active = 1;
        ta     = t - 1;
        err    = (c.op > 4'd8);
        isnot  = (c.op == 4'd2);
        isimm  = (c.op == 4'd7) || (c.op == 4'd8);
        lat    = err ? 1 : (isnot ? 6 : 8);
        if (!err) begin
          res = refResult(c.op, shadow[c.rs1], shadow[c.rs2], c.imm);
          shadow[c.rd] = res;
        end
      end
      if (nxt < prog.size()) begin
        ifc.instValid = 1'b1;
        ifc.instOp    = prog[nxt].op;
        ifc.instRd    = prog[nxt].rd;
        ifc.instRs1   = prog[nxt].rs1;
        ifc.instRs2   = prog[nxt].rs2;
        ifc.instImm   = prog[nxt].imm;
      end else begin
        ifc.instValid = 1'b0;
      end
      rel = t - ta;
      ev  = 8'b1000_0000;
      if (active && rel >= 1 && rel <= lat) begin
        if (err)
          ev = {1'b1, 6'b0, (rel == 1)};
        else
          ev = {(rel == lat),
                (rel == 1) || (rel == 2) || (!isimm && !isnot && (rel == 3 || rel == 4)),
                (rel == 2),
                (!isnot && rel == 4),
                (rel == lat - 2) || (rel == lat - 1),
                (rel == lat - 1),
                (rel == lat),
                1'b0};
      end
      checkOutput($sformatf("ctl t=%0d op=%0d rel=%0d", t, c.op, rel), ctlVector(), ev);
      if (active && !err && rel >= 1 && rel <= lat) begin
        if (ev[6]) checkOutput($sformatf("regOutSel rel=%0d", rel), ifc.regOutSel, (rel <= 2) ? c.rs1 : c.rs2);
        if (ev[3]) checkOutput($sformatf("regInSel rel=%0d", rel), ifc.regInSel, c.rd);
        if (ev[2]) checkOutput($sformatf("wb_bus op=%0d", c.op), bus, res);
        if (isimm && (rel == 3 || rel == 4)) checkOutput($sformatf("imm_bus rel=%0d", rel), bus, c.imm);
        checkOutput("aluOpCode", ifc.aluOpCode, c.op);
      end
      ready = !active || (rel >= lat);
      pend  = ready && (nxt < prog.size());
      if (!pend && nxt >= prog.size() && ready) begin
        run = 0;
      end else if (t > 400) begin
        checkOutput("timeout", finished_ok, 1);
        run = 0;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    ifc.instValid = 1'b0;
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rf[%0d]", i), rf[i], shadow[i]);
    prog.delete();
  endtask

  initial begin
    rstN          = 1'b0;
    ifc.instValid = 1'b0;
    ifc.instOp    = '0;
    ifc.instRd    = '0;
    ifc.instRs1   = '0;
    ifc.instRs2   = '0;
    ifc.instImm   = '0;

    @(negedge clk);
    checkOutput("reset_ctl", ctlVector(), 8'h80);
    checkOutput("reset_sel", {ifc.regOutSel, ifc.regInSel, ifc.aluOpCode}, 0);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) setReg(i[RW-1:0], DW'($urandom));

    $display("[TB] ADD r1 = r2 + r3");
    setReg(3'd2, 16'h0003);
    setReg(3'd3, 16'h0004);
    prog.push_back(mk(4'd0, 3'd1, 3'd2, 3'd3, 16'h0000));
    applyStimulus();

    $display("[TB] SUBI r4 = r5 - 1 with wrap");
    setReg(3'd5, 16'h0000);
    prog.push_back(mk(4'd8, 3'd4, 3'd5, 3'd6, 16'h0001));
    applyStimulus();

    $display("[TB] NOT r0 = ~r6");
    setReg(3'd6, 16'h00FF);
    prog.push_back(mk(4'd2, 3'd0, 3'd6, 3'd1, 16'h0000));
    applyStimulus();

    $display("[TB] illegal opcode 9");
    prog.push_back(mk(4'd9, 3'd2, 3'd3, 3'd4, 16'h5A5A));
    applyStimulus();

    $display("[TB] back-to-back AND then dependent XOR");
    prog.push_back(mk(4'd3, 3'd7, 3'd1, 3'd2, 16'h0000));
    prog.push_back(mk(4'd5, 3'd3, 3'd7, 3'd4, 16'h0000));
    applyStimulus();

    $display("[TB] random back-to-back streams");
    for (int b = 0; b < 6; b++) begin
      for (int n = 0; n < 6; n++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        prog.push_back(mk(op, RW'($urandom), RW'($urandom), RW'($urandom), DW'($urandom)));
      end
      applyStimulus();
    end

    $display("[TB] reset during S2_LAT");
    setReg(3'd1, 16'h1234);
    @(negedge clk);
    ifc.instValid = 1'b1;
    ifc.instOp    = 4'd0;
    ifc.instRd    = 3'd1;
    ifc.instRs1   = 3'd2;
    ifc.instRs2   = 3'd3;
    @(negedge clk);
    ifc.instValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_en2", ifc.aluEnIn2, 1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_async_ctl", ctlVector(), 8'h80);
    checkOutput("rst_async_sel", {ifc.regOutSel, ifc.regInSel, ifc.aluOpCode}, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_hold_wb", ifc.regInEn, 0);
    end
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_ready", ifc.instReady, 1);
    checkOutput("rst_no_wb", rf[1], shadow[1]);

    $display("[TB] recovery after reset");
    prog.push_back(mk(4'd6, 3'd5, 3'd2, 3'd3, 16'h0000));
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
